// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: fractional oversample/bit tick generator with shadowed, tick-aligned divisor updates.
module uart_baud_gen_frac #(
  parameter int INT_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16,
  parameter int DEF_INT  = 27,
  parameter int DEF_FRAC = 2
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    en,
  input  logic                    resync,
  input  logic [INT_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  input  logic                    div_load,
  output logic                    cfg_pending,
  output logic                    cfg_err,
  output logic                    os_tick,
  output logic                    bit_tick,
  output logic [$clog2(OSR)-1:0]  os_idx
);
  localparam int IW = $clog2(OSR);
  logic [INT_W-1:0]  act_int, sh_int, cnt, lim;
  logic [FRAC_W-1:0] act_frac, sh_frac, acc;
  logic [FRAC_W:0]   sum;
  logic              cy, wrap, apply, load_ok;
  assign sum      = {1'b0, acc} + {1'b0, act_frac};
  assign cy       = sum[FRAC_W];
  assign lim      = act_int - INT_W'(1) + INT_W'(cy);
  assign os_tick  = rstN & en & ~resync & (cnt == lim);
  assign wrap     = os_idx == IW'(OSR - 1);
  assign bit_tick = os_tick & wrap;
  assign apply    = cfg_pending & (os_tick | resync | ~en);
  assign load_ok  = div_load & (div_int != '0);
  // apply reads the pre-load shadow, so a same-cycle load stays pending
  always_ff @(posedge clk) begin
    if (!rstN) begin
      act_int     <= INT_W'(DEF_INT);
      act_frac    <= FRAC_W'(DEF_FRAC);
      sh_int      <= INT_W'(DEF_INT);
      sh_frac     <= FRAC_W'(DEF_FRAC);
      cnt         <= '0;
      acc         <= '0;
      os_idx      <= '0;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err     <= div_load & (div_int == '0);
      cfg_pending <= load_ok | (cfg_pending & ~apply);
      if (load_ok) begin
        sh_int  <= div_int;
        sh_frac <= div_frac;
      end
      if (apply) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
      end
      if (resync) begin
        cnt    <= '0;
        acc    <= '0;
        os_idx <= '0;
      end else if (os_tick) begin
        cnt    <= '0;
        acc    <= sum[FRAC_W-1:0];
        os_idx <= wrap ? '0 : os_idx + IW'(1);
      end else if (en) begin
        cnt <= cnt + INT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb_uart_baud_gen_frac: scoreboard bench; stimulus queues expected ticks/errors, a negedge monitor checks them.
module tb_uart_baud_gen_frac;
  logic        clk = 0, rstN = 0, en = 0, resync = 0, div_load = 0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        cfg_pending, cfg_err, os_tick, bit_tick;
  logic [3:0]  os_idx;
  int          cyc = 0, total = 0, bad = 0, t0;
  typedef struct {int c; int idx; logic bt;} tick_t;
  tick_t tick_q[$];
  int    err_q[$];
  int    per4[4] = '{3, 7, 11, 16};

  uart_baud_gen_frac dut (
    .clk(clk), .rstN(rstN), .en(en), .resync(resync),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .os_tick(os_tick), .bit_tick(bit_tick), .os_idx(os_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    tick_t e;
    int ec;
    if (os_tick === 1'b1) begin
      total++;
      if (tick_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tick cyc=%0d idx=%0d", cyc, os_idx);
      end else begin
        e = tick_q.pop_front();
        if (e.c != cyc || e.idx != int'(os_idx) || e.bt !== bit_tick) begin
          bad++;
          $display("FAIL tick got cyc=%0d idx=%0d bit=%0b want cyc=%0d idx=%0d bit=%0b",
                   cyc, os_idx, bit_tick, e.c, e.idx, e.bt);
        end
      end
    end
    if (bit_tick === 1'b1 && os_tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL bit_without_os cyc=%0d", cyc);
    end
    if (cfg_err === 1'b1) begin
      total++;
      if (err_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_cfg_err cyc=%0d", cyc);
      end else begin
        ec = err_q.pop_front();
        if (ec != cyc) begin
          bad++;
          $display("FAIL cfg_err got cyc=%0d want cyc=%0d", cyc, ec);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push(input int c, input int idx, input logic bt);
    tick_t e;
    e.c = c;
    e.idx = idx;
    e.bt = bt;
    tick_q.push_back(e);
  endtask

  task automatic drained(input string name);
    chk({name, "_missed_ticks"}, tick_q.size(), 0);
    chk({name, "_missed_errs"}, err_q.size(), 0);
  endtask

  // load with en low so it applies at once, then resync to zero cnt/acc/os_idx
  task automatic cfg(input int di, input int df);
    en = 0;
    div_int = 16'(di);
    div_frac = 4'(df);
    div_load = 1;
    step(1);
    div_load = 0;
    chk("pending_after_load", int'(cfg_pending), 1);
    step(1);
    chk("pending_after_apply", int'(cfg_pending), 0);
    resync = 1;
    step(1);
    resync = 0;
  endtask

  initial begin
    step(3);
    chk("rst_os_tick", int'(os_tick), 0);
    chk("rst_bit_tick", int'(bit_tick), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_pending", int'(cfg_pending), 0);
    chk("rst_os_idx", int'(os_idx), 0);
    rstN = 1;
    step(1);

    // int=4 frac=0: ticks every 4th enabled cycle, bit tick on the 16th
    cfg(4, 0);
    t0 = cyc;
    for (int k = 1; k <= 17; k++) push(t0 + 4 * k - 1, (k - 1) % 16, k == 16);
    en = 1;
    step(68);
    en = 0;
    chk("idx_after_wrap", int'(os_idx), 1);
    drained("int4");

    // int=4 frac=4: periods 4,4,4,5
    cfg(4, 4);
    t0 = cyc;
    for (int k = 1; k <= 16; k++) push(t0 + 17 * ((k - 1) / 4) + per4[(k - 1) % 4], k - 1, k == 16);
    en = 1;
    step(68);
    en = 0;
    drained("frac4");

    // mid-period load of 8 waits for the tick; then a rejected load of 0
    cfg(4, 0);
    t0 = cyc;
    push(t0 + 3, 0, 0);
    push(t0 + 11, 1, 0);
    push(t0 + 19, 2, 0);
    push(t0 + 27, 3, 0);
    push(t0 + 35, 4, 0);
    err_q.push_back(t0 + 21);
    en = 1;
    step(1);
    div_int = 16'd8;
    div_load = 1;
    step(1);
    div_load = 0;
    chk("pending_mid", int'(cfg_pending), 1);
    step(1);
    chk("pending_at_tick", int'(cfg_pending), 1);
    step(1);
    chk("pending_cleared", int'(cfg_pending), 0);
    step(16);
    div_int = 16'd0;
    div_frac = 4'd5;
    div_load = 1;
    step(1);
    div_load = 0;
    chk("pending_after_bad_load", int'(cfg_pending), 0);
    step(15);
    en = 0;
    drained("reload");

    // resync at cnt=2 idx=7 with acc=12: restart with acc cleared
    cfg(4, 4);
    t0 = cyc;
    foreach (per4[i]) push(t0 + per4[i], i, 0);
    for (int i = 0; i < 3; i++) push(t0 + 17 + per4[i], 4 + i, 0);
    foreach (per4[i]) push(t0 + 32 + per4[i], i, 0);
    en = 1;
    step(31);
    chk("idx_before_resync", int'(os_idx), 7);
    resync = 1;
    step(1);
    resync = 0;
    chk("idx_after_resync", int'(os_idx), 0);
    step(17);
    en = 0;
    drained("resync");

    // en low for 10 cycles at cnt=2, then reset mid-period
    cfg(4, 0);
    t0 = cyc;
    push(t0 + 3, 0, 0);
    push(t0 + 17, 1, 0);
    push(t0 + 21, 2, 0);
    en = 1;
    step(6);
    en = 0;
    step(10);
    en = 1;
    step(6);
    rstN = 0;
    step(1);
    chk("mid_rst_os_tick", int'(os_tick), 0);
    chk("mid_rst_os_idx", int'(os_idx), 0);
    chk("mid_rst_pending", int'(cfg_pending), 0);
    rstN = 1;
    push(t0 + 49, 0, 0);
    push(t0 + 76, 1, 0);
    step(54);
    en = 0;
    drained("en_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_baud_gen_frac.md
Name: uart_baud_gen_frac

Overview:
- Runtime-programmable fractional baud generator for the UART TX/RX datapaths.
- Produces an oversample tick (os_tick) at an average period of div_int + div_frac/2^FRAC_W clock cycles, and a bit tick (bit_tick) every OSR oversample ticks.
- Divisor changes are glitch-free: a new divisor takes effect only on a tick boundary.
- A resync input realigns the phase, so the RX path can centre sampling on a detected start bit.

Parameters:
- INT_W, 16, width of the integer divisor.
- FRAC_W, 4, width of the fractional divisor (resolution 1/2^FRAC_W cycle).
- OSR, 16, oversample ticks per bit (>=2; power of two not required).
- DEF_INT, 27, integer divisor loaded at reset (>=1).
- DEF_FRAC, 2, fractional divisor loaded at reset.

Ports:
- clk  in  1  clock
- rstN  in  1  reset, synchronous, active-low
- en  in  1  count enable; when low, all state holds and ticks are 0
- resync  in  1  phase realign pulse
- div_int  in  INT_W  new integer divisor
- div_frac  in  FRAC_W  new fractional divisor
- div_load  in  1  capture div_int/div_frac into the shadow register
- cfg_pending  out  1  shadow holds a value not yet applied
- cfg_err  out  1  one-cycle pulse: load rejected
- os_tick  out  1  one-cycle oversample pulse
- bit_tick  out  1  one-cycle bit pulse, coincident with an os_tick
- os_idx  out  max(1,$clog2(OSR))  current oversample index, 0..OSR-1

Behaviour:
- Registers:
  - act_int / act_frac: active divisor.
  - sh_int / sh_frac: shadow divisor.
  - cnt: INT_W wide.
  - acc: FRAC_W wide.
  - os_idx, cfg_pending.
- Reset (rstN=0 at a clk edge), with priority over everything else:
  - act and sh = DEF_INT/DEF_FRAC.
  - cnt=0, acc=0, os_idx=0, cfg_pending=0.
  - os_tick=bit_tick=cfg_err=0.
- Combinational terms:
  - cy = carry-out of acc + act_frac.
  - lim = act_int - 1 + cy.
  - os_tick = en & ~resync & (cnt == lim).
  - bit_tick = os_tick & (os_idx == OSR-1).
  - Ticks are combinational from registers and the en/resync inputs, with no input-to-tick path through the divisor inputs.
- Counting (en=1, resync=0):
  - If cnt==lim: cnt<=0, acc<=acc+act_frac (mod 2^FRAC_W), os_idx<=(os_idx==OSR-1)?0:os_idx+1.
  - Otherwise cnt<=cnt+1.
- Period rule: each os_tick period is act_int+cy cycles, so N consecutive periods sum to N*act_int + floor((acc0+N*act_frac)/2^FRAC_W).
- Special divisors:
  - act_int=1, act_frac=0: os_tick every enabled cycle.
  - act_frac=0: strictly periodic.
- en=0: cnt, acc and os_idx hold; ticks are 0; config still loads.
- resync=1 (with en either value):
  - cnt<=0, acc<=0, os_idx<=0.
  - Ticks forced 0 that cycle.
  - The pending shadow is applied if cfg_pending.
  - resync has priority over counting.
- Load:
  - div_load with div_int>=1: sh<=inputs, cfg_pending<=1.
  - div_load with div_int==0: shadow unchanged; cfg_err=1 in the following cycle (registered pulse); cfg_pending unchanged.
- Apply (cfg_pending=1), in a cycle where os_tick=1, resync=1, or en=0:
  - act<=sh, cfg_pending<=0.
  - The new divisor governs the period starting the next cycle.
  - acc is not cleared on apply, except by resync.
- Simultaneous apply and valid load in the same cycle:
  - Apply uses the pre-load shadow.
  - The new load then becomes pending (cfg_pending stays 1).
  - Back-to-back loads without an apply: the last one wins.
- Mid-operation reset: state returns to its reset values at the next edge; there is no partial tick.
- No multicycle or handshake on the divisor inputs; sampling happens only on div_load.

Test Plan:
- Reset, then load int=4 frac=0 (applied while en=0), en=1 → os_tick on enabled cycles 4,8,12,…; bit_tick on cycle 64 with os_idx=15 at that tick; os_idx wraps to 0.
- int=4, frac=4 (FRAC_W=4), en=1 → tick periods 4,4,4,5 repeating; 17 cycles per 4 ticks; 68 cycles per 16 ticks.
- Running at int=4; load int=8 mid-period → current period still ends at 4 with cfg_pending=1; cfg_pending falls at that tick; next period 8.
- div_load with div_int=0 → cfg_err pulses 1 cycle; period unchanged; cfg_pending unchanged.
- resync pulse at cnt=2, os_idx=7 (int=4) → no tick that cycle; next os_tick 4 cycles later with os_idx advancing 0→1; acc cleared.
- en low for 10 cycles at cnt=2, then high → no ticks while low; next tick after 2 more enabled cycles. rstN low mid-period → outputs 0, act=DEF_INT/DEF_FRAC.
